// File: rtl/colour_encode_writer.sv
// RGB pixel stream -> BT.601 YUV, two pixels packed per 16-bit word, written
// to the frame SRAM as separate Y, U and V planes.
module colour_encode_writer #(
  parameter int WORDS  = 38400,
  parameter int Y_BASE = 0,
  parameter int U_BASE = 38400,
  parameter int V_BASE = 76800,
  parameter int AW     = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [23:0]   pix_rgb,
  output logic          pix_ready,
  output logic          W_en,
  output logic [AW-1:0] W_addr,
  output logic [15:0]   W_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_EVEN, S_GET_ODD, S_WR_Y, S_WR_U, S_WR_V, S_DONE
  } state_t;

  localparam logic [AW-1:0] Y_BASE_A = AW'(Y_BASE);
  localparam logic [AW-1:0] U_BASE_A = AW'(U_BASE);
  localparam logic [AW-1:0] V_BASE_A = AW'(V_BASE);
  localparam logic [AW-1:0] K_LAST   = AW'(WORDS - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] k_reg, k_next;

  logic [7:0]    y_even_reg, u_even_reg, v_even_reg;
  logic [7:0]    u_odd_reg, v_odd_reg;
  logic [AW-1:0] w_addr_reg;
  logic [15:0]   w_data_reg;

  logic          take_even, take_odd;

  // Colour conversion, combinational on the offered pixel
  logic signed [17:0] r_s, g_s, b_s;
  logic signed [17:0] y_sum, u_sum, v_sum;
  logic signed [17:0] y_val, u_val, v_val;
  logic [7:0]         y_conv, u_conv, v_conv;

  function automatic logic [7:0] clamp8(input logic signed [17:0] x);
    if (x[17])
      return 8'd0;
    else if (x > 18'sd255)
      return 8'hFF;
    else
      return x[7:0];
  endfunction

  assign r_s = $signed({10'd0, pix_rgb[23:16]});
  assign g_s = $signed({10'd0, pix_rgb[15:8]});
  assign b_s = $signed({10'd0, pix_rgb[7:0]});

  assign y_sum = 18'sd66 * r_s + 18'sd129 * g_s + 18'sd25 * b_s + 18'sd128;
  assign u_sum = 18'sd112 * b_s - 18'sd38 * r_s - 18'sd74 * g_s + 18'sd128;
  assign v_sum = 18'sd112 * r_s - 18'sd94 * g_s - 18'sd18 * b_s + 18'sd128;

  // Arithmetic shift floors negative sums before the offset is added
  assign y_val = (y_sum >>> 8) + 18'sd16;
  assign u_val = (u_sum >>> 8) + 18'sd128;
  assign v_val = (v_sum >>> 8) + 18'sd128;

  assign y_conv = clamp8(y_val);
  assign u_conv = clamp8(u_val);
  assign v_conv = clamp8(v_val);

  // State decodes
  assign pix_ready = (state_reg == S_GET_EVEN) || (state_reg == S_GET_ODD);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign W_en      = (state_reg == S_WR_Y) || (state_reg == S_WR_U) || (state_reg == S_WR_V);
  assign W_addr    = w_addr_reg;
  assign W_data    = w_data_reg;

  assign take_even = (state_reg == S_GET_EVEN) && pix_valid;
  assign take_odd  = (state_reg == S_GET_ODD) && pix_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_GET_EVEN;
          k_next     = '0;
        end
      end
      S_GET_EVEN: if (pix_valid) state_next = S_GET_ODD;
      S_GET_ODD:  if (pix_valid) state_next = S_WR_Y;
      S_WR_Y:     state_next = S_WR_U;
      S_WR_U:     state_next = S_WR_V;
      S_WR_V: begin
        if (k_reg == K_LAST) begin
          state_next = S_DONE;
        end else begin
          state_next = S_GET_EVEN;
          k_next     = k_reg + 1'b1;
        end
      end
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Address/data are loaded one cycle ahead so they line up with W_en;
  // the odd Y byte goes straight from the converter into the first word.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_even_reg <= '0;
      u_even_reg <= '0;
      v_even_reg <= '0;
      u_odd_reg  <= '0;
      v_odd_reg  <= '0;
      w_addr_reg <= '0;
      w_data_reg <= '0;
    end else begin
      if (take_even) begin
        y_even_reg <= y_conv;
        u_even_reg <= u_conv;
        v_even_reg <= v_conv;
      end
      if (take_odd) begin
        u_odd_reg  <= u_conv;
        v_odd_reg  <= v_conv;
        w_addr_reg <= Y_BASE_A + k_reg;
        w_data_reg <= {y_conv, y_even_reg};
      end
      if (state_reg == S_WR_Y) begin
        w_addr_reg <= U_BASE_A + k_reg;
        w_data_reg <= {u_odd_reg, u_even_reg};
      end
      if (state_reg == S_WR_U) begin
        w_addr_reg <= V_BASE_A + k_reg;
        w_data_reg <= {v_odd_reg, v_even_reg};
      end
    end
  end

endmodule
